vertex_transformer: RTL and testbench

//  Vertex-shader stage. Multiplies an object-space vertex (x,y,z,w=1) by a 4x4 MVP matrix.

---
 rtl/vertex_transformer_if.sv | 27 ++
 rtl/vertex_transformer.sv | 125 ++++++++++++
 tb/tb_vertex_transformer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/vertex_transformer_if.sv
// Vertex transformer bus: matrix load, vertex input handshake and
// clip-space output toward the post-processor.
interface vertex_transformer_if #(
    parameter int DATAWIDTH = 24
);
    logic [15:0][DATAWIDTH-1:0] i_mvp;
    logic                       i_mvp_dv;
    logic                       ready;
    logic [2:0][DATAWIDTH-1:0]  i_vertex;
    logic                       i_vertex_dv;
    logic                       i_pp_ready;
    logic [3:0][DATAWIDTH-1:0]  o_vertex;
    logic                       o_vertex_dv;
    logic                       o_ovf;

    // upstream/downstream environment side
    modport master (
        output i_mvp, i_mvp_dv, i_vertex, i_vertex_dv, i_pp_ready,
        input  ready, o_vertex, o_vertex_dv, o_ovf
    );

    // transformer side
    modport slave (
        input  i_mvp, i_mvp_dv, i_vertex, i_vertex_dv, i_pp_ready,
        output ready, o_vertex, o_vertex_dv, o_ovf
    );
endinterface

// File: rtl/vertex_transformer.sv
// Vertex-shader stage: clip = MVP * (x,y,z,1) using one shared signed
// multiplier over 12 MAC cycles; column 3 is added as a bias at row commit.
module vertex_transformer #(
    parameter int DATAWIDTH = 24,
    parameter int FRACBITS  = 13
) (
    input  logic                 clk,
    input  logic                 rstn,
    vertex_transformer_if.slave  bus
);
    localparam int AW = 2*DATAWIDTH + 3;

    localparam logic signed [AW-1:0] MAXV =
        {{(AW-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV =
        {{(AW-DATAWIDTH+1){1'b1}}, {(DATAWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;

    state_t                      r_state;
    logic                        r_loaded;
    logic [15:0][DATAWIDTH-1:0]  r_m;
    logic [2:0][DATAWIDTH-1:0]   r_v;
    logic [1:0]                  r_row;
    logic [1:0]                  r_col;
    logic signed [AW-1:0]        r_acc;
    logic                        r_ovf_acc;

    logic                        w_ready;
    logic                        w_accept;
    logic signed [DATAWIDTH-1:0] w_ma;
    logic signed [DATAWIDTH-1:0] w_vb;
    logic signed [DATAWIDTH-1:0] w_bias;
    logic signed [2*DATAWIDTH-1:0] w_prod;
    logic signed [AW-1:0]        w_prod_x;
    logic signed [AW-1:0]        w_bias_x;
    logic signed [AW-1:0]        w_sum;
    logic signed [AW-1:0]        w_tot;
    logic signed [AW-1:0]        w_shr;
    logic                        w_clip;
    logic [DATAWIDTH-1:0]        w_res;

    // a matrix load in the same cycle takes priority over a vertex
    assign w_ready  = (r_state == IDLE) && r_loaded && !bus.i_mvp_dv;
    assign w_accept = w_ready && bus.i_vertex_dv;
    assign bus.ready       = w_ready;
    assign bus.o_vertex_dv = (r_state == EMIT) && bus.i_pp_ready;

    // {row,col} is exactly the row-major matrix index 4*r+c
    assign w_ma   = r_m[{r_row, r_col}];
    assign w_bias = r_m[{r_row, 2'd3}];

    // vertex component select for the shared multiplier (col is 0..2 in MAC)
    always_comb begin
        w_vb = r_v[0];
        case (r_col)
            2'd1:    w_vb = r_v[1];
            2'd2:    w_vb = r_v[2];
            default: ;
        endcase
    end

    assign w_prod   = w_ma * w_vb;
    assign w_prod_x = {{3{w_prod[2*DATAWIDTH-1]}}, w_prod};
    assign w_bias_x = {{(AW-DATAWIDTH-FRACBITS){w_bias[DATAWIDTH-1]}}, w_bias, {FRACBITS{1'b0}}};
    assign w_sum    = r_acc + w_prod_x;
    assign w_tot    = w_sum + w_bias_x;
    assign w_shr    = w_tot >>> FRACBITS;          // floor, no rounding
    assign w_clip   = (w_shr > MAXV) || (w_shr < MINV);
    assign w_res    = !w_clip ? w_shr[DATAWIDTH-1:0] :
                      (w_shr[AW-1] ? {1'b1, {(DATAWIDTH-1){1'b0}}}
                                   : {1'b0, {(DATAWIDTH-1){1'b1}}});

    // control FSM, MAC datapath and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_loaded     <= 1'b0;
            r_m          <= '0;
            r_v          <= '0;
            r_row        <= 2'd0;
            r_col        <= 2'd0;
            r_acc        <= '0;
            r_ovf_acc    <= 1'b0;
            bus.o_vertex <= '0;
            bus.o_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.i_mvp_dv) begin
                        r_m      <= bus.i_mvp;
                        r_loaded <= 1'b1;
                    end else if (w_accept) begin
                        r_v       <= bus.i_vertex;
                        r_row     <= 2'd0;
                        r_col     <= 2'd0;
                        r_acc     <= '0;
                        r_ovf_acc <= 1'b0;
                        r_state   <= MAC;
                    end
                end
                MAC: begin
                    if (r_col == 2'd2) begin
                        bus.o_vertex[r_row] <= w_res;
                        if (w_clip) r_ovf_acc <= 1'b1;
                        r_acc <= '0;
                        r_col <= 2'd0;
                        r_row <= r_row + 2'd1;
                        if (r_row == 2'd3) r_state <= EMIT;
                    end else begin
                        r_acc <= w_sum;
                        r_col <= r_col + 2'd1;
                    end
                end
                EMIT: begin
                    if (bus.i_pp_ready) begin
                        bus.o_ovf <= r_ovf_acc;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vertex_transformer.sv
// Directed + randomized bench for vertex_transformer with a behavioural
// matrix-times-vector reference model.
module tb_vertex_transformer;
    logic clk = 1'b0;
    logic rstn;
    int   n_tot  = 0;
    int   n_pass = 0;
    longint m [16];

    vertex_transformer_if bus ();

    vertex_transformer dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // clip = M * (x,y,z,1), floor of the Q13 result, saturated to 24 bits
    task automatic model(input longint vx, input longint vy, input longint vz,
                         output logic [95:0] ov, output logic of);
        longint s, q;
        of = 1'b0;
        ov = '0;
        for (int r = 0; r < 4; r++) begin
            s = m[4*r]*vx + m[4*r+1]*vy + m[4*r+2]*vz + m[4*r+3]*8192;
            q = s >>> 13;
            if (q > 8388607)       begin q = 8388607;  of = 1'b1; end
            else if (q < -8388608) begin q = -8388608; of = 1'b1; end
            ov[r*24 +: 24] = q[23:0];
        end
    endtask

    function automatic longint rnd(input int bits);
        return longint'($urandom & ((1 << bits) - 1)) - (longint'(1) << (bits - 1));
    endfunction

    task automatic identity();
        for (int i = 0; i < 16; i++) m[i] = (i % 5 == 0) ? 8192 : 0;
    endtask

    task automatic load_mat();
        @(negedge clk);
        for (int i = 0; i < 16; i++) bus.i_mvp[i] = m[i][23:0];
        bus.i_mvp_dv = 1'b1;
        @(negedge clk);
        bus.i_mvp_dv = 1'b0;
    endtask

    // one full vertex transaction; bp = cycles of held-off pp_ready in EMIT,
    // midload = pulse a bogus matrix load while the MAC is running
    task automatic run_vertex(input longint vx, input longint vy, input longint vz,
                              input int bp, input bit midload);
        logic [95:0] ev;
        logic        eo;
        int          cnt;
        model(vx, vy, vz, ev, eo);
        @(negedge clk);
        chk("ready_idle", bus.ready, 1);
        bus.i_vertex[0] = vx[23:0];
        bus.i_vertex[1] = vy[23:0];
        bus.i_vertex[2] = vz[23:0];
        bus.i_vertex_dv = 1'b1;
        bus.i_pp_ready  = (bp == 0);
        @(negedge clk);
        bus.i_vertex_dv = 1'b0;
        chk("ready_busy", bus.ready, 0);
        cnt = 0;
        if (bp == 0) begin
            while (!bus.o_vertex_dv && cnt < 40) begin
                if (midload && cnt == 3) begin
                    for (int i = 0; i < 16; i++) bus.i_mvp[i] = 24'h123456;
                    bus.i_mvp_dv = 1'b1;
                end else begin
                    bus.i_mvp_dv = 1'b0;
                end
                @(negedge clk);
                cnt++;
            end
            bus.i_mvp_dv = 1'b0;
            chk("latency", cnt, 12);
            chk("vertex", bus.o_vertex, ev);
        end else begin
            repeat (12) @(negedge clk);
            for (int i = 0; i < bp; i++) begin
                chk("bp_dv", bus.o_vertex_dv, 0);
                chk("bp_ready", bus.ready, 0);
                chk("bp_vertex", bus.o_vertex, ev);
                @(negedge clk);
            end
            bus.i_pp_ready = 1'b1;
            #1;
            chk("bp_rise_dv", bus.o_vertex_dv, 1);
            chk("bp_rise_vertex", bus.o_vertex, ev);
        end
        @(negedge clk);
        chk("dv_pulse_end", bus.o_vertex_dv, 0);
        chk("ready_after", bus.ready, 1);
        chk("ovf", bus.o_ovf, eo);
    endtask

    initial begin
        bit seen;
        rstn            = 1'b0;
        bus.i_mvp       = '0;
        bus.i_mvp_dv    = 1'b0;
        bus.i_vertex    = '0;
        bus.i_vertex_dv = 1'b0;
        bus.i_pp_ready  = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_vertex", bus.o_vertex, 0);
        chk("rst_ovf", bus.o_ovf, 0);
        chk("rst_dv", bus.o_vertex_dv, 0);
        chk("rst_ready", bus.ready, 0);
        rstn = 1'b1;

        // vertex offered before any matrix: never accepted
        bus.i_vertex_dv = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.o_vertex_dv || bus.ready) seen = 1'b1;
        end
        bus.i_vertex_dv = 1'b0;
        chk("noload_no_accept", seen, 0);

        // identity
        identity();
        load_mat();
        run_vertex(8192, -16384, 4096, 0, 1'b0);
        chk("c1_const", bus.o_vertex, {24'd8192, 24'd4096, 24'hFFC000, 24'd8192});

        // bias column and negative w
        identity();
        m[3] = 24576; m[14] = -8192; m[15] = 0;
        load_mat();
        run_vertex(8192, 0, 16384, 0, 1'b0);
        chk("c2_const", bus.o_vertex, {24'hFFC000, 24'd16384, 24'd0, 24'd32768});

        // backpressure
        identity();
        load_mat();
        run_vertex(-12345, 777, 65536, 5, 1'b0);

        // saturation, then a clean vertex clears ovf
        identity();
        m[0] = 8388607;
        load_mat();
        run_vertex(8388607, 0, 0, 0, 1'b0);
        chk("sat_x", bus.o_vertex[0], 24'd8388607);
        identity();
        load_mat();
        run_vertex(100, 200, 300, 0, 1'b0);

        // matrix load pulsed during MAC is ignored
        for (int i = 0; i < 16; i++) m[i] = rnd(16);
        load_mat();
        run_vertex(rnd(20), rnd(20), rnd(20), 0, 1'b1);

        // simultaneous matrix and vertex valid: matrix wins, no accept
        identity();
        for (int i = 0; i < 16; i++) m[i] = m[i] * 2;
        @(negedge clk);
        for (int i = 0; i < 16; i++) bus.i_mvp[i] = m[i][23:0];
        bus.i_mvp_dv    = 1'b1;
        bus.i_vertex_dv = 1'b1;
        #1;
        chk("both_ready", bus.ready, 0);
        @(negedge clk);
        bus.i_mvp_dv    = 1'b0;
        bus.i_vertex_dv = 1'b0;
        seen = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (bus.o_vertex_dv) seen = 1'b1;
        end
        chk("both_no_accept", seen, 0);
        run_vertex(1000, -2000, 3000, 0, 1'b0);

        // randomized matrices and vertices, some wide enough to saturate
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 16; i++) m[i] = (k % 3 == 2) ? rnd(24) : rnd(18);
            load_mat();
            run_vertex(rnd(k % 3 == 2 ? 24 : 20), rnd(20), rnd(20),
                       int'($urandom_range(0, 3)), 1'b0);
        end

        // reset in the middle of MAC aborts the vertex
        identity();
        load_mat();
        @(negedge clk);
        bus.i_vertex[0] = 24'd8192;
        bus.i_vertex[1] = 24'd8192;
        bus.i_vertex[2] = 24'd8192;
        bus.i_vertex_dv = 1'b1;
        @(negedge clk);
        bus.i_vertex_dv = 1'b0;
        repeat (6) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mrst_vertex", bus.o_vertex, 0);
        chk("mrst_ovf", bus.o_ovf, 0);
        chk("mrst_ready", bus.ready, 0);
        chk("mrst_dv", bus.o_vertex_dv, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        seen = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (bus.o_vertex_dv || bus.ready) seen = 1'b1;
        end
        chk("mrst_no_emit", seen, 0);
        load_mat();
        run_vertex(8192, -16384, 4096, 0, 1'b0);
        chk("mrst_c1_const", bus.o_vertex, {24'd8192, 24'd4096, 24'hFFC000, 24'd8192});

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
